// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - bus layouts and load-op encoding shared by the MEM stage
package mem_pkg;

    // ex_to_mem_bus: {side, ld_op, mem_req, rf_we, rf_waddr, alu_result, pc}
    localparam int EX_PC_LSB    = 0;
    localparam int EX_ALU_LSB   = 32;
    localparam int EX_WADDR_LSB = 64;
    localparam int EX_WE_BIT    = 69;
    localparam int EX_REQ_BIT   = 70;
    localparam int EX_LDOP_LSB  = 71;
    localparam int EX_SIDE_LSB  = 76;

    // mem_to_wb_bus: {side, rf_we, rf_waddr, final_wdata, pc}
    localparam int WB_PC_LSB    = 0;
    localparam int WB_WDATA_LSB = 32;
    localparam int WB_WADDR_LSB = 64;
    localparam int WB_WE_BIT    = 69;
    localparam int WB_SIDE_LSB  = 70;

    localparam int LD_OP_W = 5;
    localparam int LD_B    = 0;
    localparam int LD_H    = 1;
    localparam int LD_W    = 2;
    localparam int LD_BU   = 3;
    localparam int LD_HU   = 4;

    typedef logic [LD_OP_W-1:0] ld_op_t;

    // Positions inside the opaque CSR/exception sideband
    localparam int SIDE_EXCEP_EN = 0;
    localparam int SIDE_ERTN     = 1;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - byte/half/word selection and extension of load data
module load_align
    import mem_pkg::*;
(
    input  ld_op_t      ld_op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (off)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];

        ext = 32'd0;
        if (ld_op[LD_B])
            ext = {{24{byte_v[7]}}, byte_v};
        else if (ld_op[LD_BU])
            ext = {24'd0, byte_v};
        else if (ld_op[LD_H])
            ext = {{16{half_v[15]}}, half_v};
        else if (ld_op[LD_HU])
            ext = {16'd0, half_v};
        else if (ld_op[LD_W])
            ext = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LoongArch MEM stage: response wait, load align, forwarding, orphan tracking
module mem_stage
    import mem_pkg::*;
#(
    parameter int SIDE_W = 137
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ex_to_mem_valid,
    output logic                  mem_allowin,
    input  logic [76+SIDE_W-1:0]  ex_to_mem_bus,
    input  logic                  data_sram_data_ok,
    input  logic [31:0]           data_sram_rdata,
    output logic                  mem_to_wb_valid,
    input  logic                  wb_allowin,
    output logic [70+SIDE_W-1:0]  mem_to_wb_bus,
    output logic [38:0]           mem_to_id_bus,
    input  logic                  flush,
    output logic                  mem_ex
);

    logic                  mem_valid;
    logic [76+SIDE_W-1:0]  ex_bus_r;
    logic                  rbuf_valid;
    logic [31:0]           rbuf;
    logic [1:0]            discard_cnt;
    logic [1:0]            discard_nxt;

    logic [31:0]           pc;
    logic [31:0]           alu_result;
    logic [4:0]            rf_waddr;
    logic                  rf_we;
    logic                  mem_req;
    ld_op_t                ld_op;
    logic [SIDE_W-1:0]     side;

    logic                  own_ok;
    logic                  mem_ready_go;
    logic                  in_wait;
    logic                  discard_inc;
    logic                  discard_dec;
    logic [31:0]           load_src;
    logic [31:0]           load_data;
    logic [31:0]           final_wdata;

    assign pc         = ex_bus_r[EX_PC_LSB +: 32];
    assign alu_result = ex_bus_r[EX_ALU_LSB +: 32];
    assign rf_waddr   = ex_bus_r[EX_WADDR_LSB +: 5];
    assign rf_we      = ex_bus_r[EX_WE_BIT];
    assign mem_req    = ex_bus_r[EX_REQ_BIT];
    assign ld_op      = ex_bus_r[EX_LDOP_LSB +: LD_OP_W];
    assign side       = ex_bus_r[EX_SIDE_LSB +: SIDE_W];

    // A response only belongs to us once every orphan ahead of it has drained
    assign own_ok       = data_sram_data_ok & (discard_cnt == 2'd0);
    assign mem_ready_go = !mem_req | rbuf_valid | own_ok;
    assign mem_allowin  = !mem_valid | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid & mem_ready_go & !flush;
    assign in_wait      = mem_valid & mem_req & !rbuf_valid;

    assign discard_dec = data_sram_data_ok & (discard_cnt != 2'd0);
    assign discard_inc = flush & in_wait & !own_ok;

    always_comb begin
        discard_nxt = discard_cnt;
        if (discard_inc && !discard_dec && discard_cnt != 2'd3)
            discard_nxt = discard_cnt + 2'd1;
        else if (discard_dec && !discard_inc)
            discard_nxt = discard_cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid   <= 1'b0;
            rbuf_valid  <= 1'b0;
            discard_cnt <= 2'd0;
            ex_bus_r    <= '0;
        end else begin
            discard_cnt <= discard_nxt;
            if (flush) begin
                mem_valid  <= 1'b0;
                rbuf_valid <= 1'b0;
            end else begin
                if (mem_allowin)
                    mem_valid <= ex_to_mem_valid;
                if (ex_to_mem_valid && mem_allowin)
                    ex_bus_r <= ex_to_mem_bus;
                // allowin while valid means the instruction is leaving
                if (mem_allowin)
                    rbuf_valid <= 1'b0;
                else if (in_wait && own_ok)
                    rbuf_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_wait && own_ok)
            rbuf <= data_sram_rdata;
    end

    assert property (@(posedge clk) disable iff (!resetn)
        !(discard_inc && !discard_dec && discard_cnt == 2'd3));

    assign load_src = rbuf_valid ? rbuf : data_sram_rdata;

    load_align u_load_align (
        .ld_op (ld_op),
        .off   (alu_result[1:0]),
        .rdata (load_src),
        .ext   (load_data)
    );

    assign final_wdata   = (|ld_op) ? load_data : alu_result;
    assign mem_to_wb_bus = {side, rf_we, rf_waddr, final_wdata, pc};
    assign mem_to_id_bus = {mem_valid & rf_we, rf_waddr, final_wdata,
                            mem_valid & (|ld_op) & !mem_ready_go};
    assign mem_ex        = mem_valid & (side[SIDE_EXCEP_EN] | side[SIDE_ERTN]);

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized bench for mem_stage against a tagged-response reference model
module tb_mem_stage;

    localparam int SIDE_W = 137;
    localparam int EXC    = mem_pkg::SIDE_EXCEP_EN;
    localparam int ERT    = mem_pkg::SIDE_ERTN;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 ex_to_mem_valid;
    logic                 mem_allowin;
    logic [76+SIDE_W-1:0] ex_to_mem_bus;
    logic                 data_sram_data_ok;
    logic [31:0]          data_sram_rdata;
    logic                 mem_to_wb_valid;
    logic                 wb_allowin;
    logic [70+SIDE_W-1:0] mem_to_wb_bus;
    logic [38:0]          mem_to_id_bus;
    logic                 flush;
    logic                 mem_ex;

    always #5 clk = ~clk;

    mem_stage #(.SIDE_W(SIDE_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_to_mem_valid   (ex_to_mem_valid),
        .mem_allowin       (mem_allowin),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .mem_to_id_bus     (mem_to_id_bus),
        .flush             (flush),
        .mem_ex            (mem_ex)
    );

    typedef struct {
        logic [31:0]       pc;
        logic [31:0]       alu;
        logic              we;
        logic [4:0]        waddr;
        logic              mem_req;
        logic [4:0]        ld_op;
        logic [SIDE_W-1:0] side;
        int                id;
    } instr_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        int          issue;
        bit          killed;
    } resp_t;

    instr_t      ex_i;
    instr_t      cur;
    bit          cur_valid;
    bit          cur_got;
    logic [31:0] cur_data;
    resp_t       memq[$];
    logic [31:0] req_rdata;
    int          next_id;
    int          cyc;
    bit          ex_taken;

    int errors = 0;
    int checks = 0;

    logic        obs_wb_valid, obs_fwd_we, obs_ld_pending, obs_mem_ex, obs_allowin;
    logic [31:0] obs_wdata;

    assign ex_to_mem_bus = {ex_i.side, ex_i.ld_op, ex_i.mem_req, ex_i.we, ex_i.waddr, ex_i.alu, ex_i.pc};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] off, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> (off * 8));
        h = 16'(d >> (off[1] * 16));
        case (op)
            5'b00001: return {{24{b[7]}}, b};
            5'b01000: return {24'd0, b};
            5'b00010: return {{16{h[15]}}, h};
            5'b10000: return {16'd0, h};
            default:  return d;
        endcase
    endfunction

    task automatic do_cycle();
        bit          own_ok, ready, is_ld, exp_allowin;
        logic [31:0] d, exp_wd;
        own_ok      = data_sram_data_ok && memq.size() > 0 && !memq[0].killed;
        ready       = !cur.mem_req || cur_got || own_ok;
        is_ld       = |cur.ld_op;
        exp_allowin = !cur_valid || (ready && wb_allowin);
        d           = cur_got ? cur_data : data_sram_rdata;
        exp_wd      = is_ld ? ref_load(cur.ld_op, cur.alu[1:0], d) : cur.alu;

        @(negedge clk);
        obs_wb_valid   = mem_to_wb_valid;
        obs_wdata      = mem_to_wb_bus[63:32];
        obs_fwd_we     = mem_to_id_bus[38];
        obs_ld_pending = mem_to_id_bus[0];
        obs_mem_ex     = mem_ex;
        obs_allowin    = mem_allowin;
        check("allowin", mem_allowin, exp_allowin);
        check("wb_valid", mem_to_wb_valid, cur_valid && ready && !flush);
        check("fwd_we", mem_to_id_bus[38], cur_valid && cur.we);
        check("ld_pending", mem_to_id_bus[0], cur_valid && is_ld && !ready);
        check("mem_ex", mem_ex, cur_valid && (cur.side[EXC] || cur.side[ERT]));
        if (cur_valid && ready) begin
            check("wb_bus", mem_to_wb_bus, {cur.side, cur.we, cur.waddr, exp_wd, cur.pc});
            check("fwd_data", mem_to_id_bus[37:1], {cur.waddr, exp_wd});
        end

        @(posedge clk);
        ex_taken = 0;
        if (data_sram_data_ok && memq.size() > 0)
            memq.delete(0);
        if (flush) begin
            if (cur_valid && cur.mem_req && !cur_got && !own_ok)
                foreach (memq[j]) if (memq[j].id == cur.id) memq[j].killed = 1;
            cur_valid = 0;
        end else begin
            if (cur_valid && own_ok) begin
                cur_got  = 1;
                cur_data = data_sram_rdata;
            end
            if (exp_allowin) begin
                cur_valid = ex_to_mem_valid;
                if (ex_to_mem_valid) begin
                    cur      = ex_i;
                    cur_got  = 0;
                    ex_taken = 1;
                    if (ex_i.mem_req)
                        memq.push_back('{id: ex_i.id, rdata: req_rdata, issue: cyc, killed: 0});
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] alu, input logic we,
                          input logic [4:0] waddr, input logic req, input logic [4:0] op,
                          input logic exc, input logic [31:0] rd);
        ex_i.pc = pc; ex_i.alu = alu; ex_i.we = we; ex_i.waddr = waddr;
        ex_i.mem_req = req; ex_i.ld_op = op;
        for (int i = 0; i < SIDE_W; i++) ex_i.side[i] = 1'($urandom);
        ex_i.side[EXC] = exc;
        ex_i.side[ERT] = 1'b0;
        ex_i.id = next_id++;
        req_rdata = rd;
    endtask

    task automatic gen_instr();
        int kind;
        kind = $urandom_range(0, 2);
        set_ex($urandom, $urandom, 1'($urandom), 5'($urandom), kind != 0,
               (kind == 1) ? (5'd1 << $urandom_range(0, 4)) : 5'd0,
               ($urandom % 8) == 0, $urandom);
        if (kind == 1) ex_i.we = 1'b1;
        ex_i.side[ERT] = ($urandom % 8) == 0;
    endtask

    task automatic drive(input logic v, input logic ok, input logic [31:0] rd,
                         input logic wa, input logic fl);
        ex_to_mem_valid = v; data_sram_data_ok = ok; data_sram_rdata = rd;
        wb_allowin = wa; flush = fl;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 32'd0, 1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_allowin", mem_allowin, 1'b1);
        check("rst_wb_valid", mem_to_wb_valid, 1'b0);
        check("rst_id_bus", mem_to_id_bus, 39'd0);
        check("rst_wb_bus", mem_to_wb_bus, '0);
        check("rst_mem_ex", mem_ex, 1'b0);
        @(posedge clk); #1;
        resetn    = 1'b1;
        cur_valid = 0;
        cur_got   = 0;
        memq.delete();
    endtask

    task automatic run_random(input int n);
        bit have;
        int killed;
        have = 0;
        for (int k = 0; k < n; k++) begin
            killed = 0;
            foreach (memq[j]) if (memq[j].killed) killed++;
            flush      = (killed <= 2) && (($urandom % 12) == 0);
            wb_allowin = ($urandom % 4) != 0;
            if (!have) begin
                gen_instr();
                ex_to_mem_valid = ($urandom % 4) != 0;
                have = ex_to_mem_valid;
            end
            if (memq.size() > 0 && memq[0].issue < cyc && ($urandom % 3) == 0) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = memq[0].rdata;
            end else begin
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom;
            end
            do_cycle();
            if (ex_taken || flush) have = 0;
        end
    endtask

    initial begin
        next_id = 1; cyc = 0; ex_taken = 0;
        cur = '{pc: 0, alu: 0, we: 0, waddr: 0, mem_req: 0, ld_op: 0, side: '0, id: 0};
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // ALU op: one cycle through MEM
        set_ex(32'h1c000000, 32'h1234, 1, 5'd4, 0, 5'b00000, 0, 0);
        drive(1, 0, 0, 1, 0); do_cycle();
        drive(0, 0, 0, 1, 0); do_cycle();
        check("alu_valid", obs_wb_valid, 1'b1);
        check("alu_wdata", obs_wdata, 32'h1234);
        check("alu_fwd_we", obs_fwd_we, 1'b1);

        // ld_b off=3, response three cycles late
        set_ex(32'h1c000004, 32'h00001003, 1, 5'd7, 1, 5'b00001, 0, 32'h80FF0000);
        drive(1, 0, 0, 1, 0); do_cycle();
        repeat (3) begin
            drive(0, 0, $urandom, 1, 0); do_cycle();
            check("ldb_pending", obs_ld_pending, 1'b1);
        end
        drive(0, 1, 32'h80FF0000, 1, 0); do_cycle();
        check("ldb_valid", obs_wb_valid, 1'b1);
        check("ldb_wdata", obs_wdata, 32'hFFFFFF80);

        // ld_hu off=2 captured while WB stalls
        set_ex(32'h1c000008, 32'h00002002, 1, 5'd9, 1, 5'b10000, 0, 32'hBEEF1234);
        drive(1, 0, 0, 1, 0); do_cycle();
        drive(0, 1, 32'hBEEF1234, 0, 0); do_cycle();
        check("ldhu_hold_valid", obs_wb_valid, 1'b1);
        drive(0, 0, 32'h5A5A5A5A, 1, 0); do_cycle();
        check("ldhu_valid", obs_wb_valid, 1'b1);
        check("ldhu_wdata", obs_wdata, 32'h0000BEEF);

        // flush in WAIT, orphan response must not reach the next load
        set_ex(32'h1c00000c, 32'h00003000, 1, 5'd3, 1, 5'b00100, 0, 32'h11112222);
        drive(1, 0, 0, 1, 0); do_cycle();
        drive(0, 0, 32'h0, 1, 1); do_cycle();
        set_ex(32'h1c000010, 32'h00003004, 1, 5'd6, 1, 5'b00100, 0, 32'h33334444);
        drive(1, 0, 0, 1, 0); do_cycle();
        drive(0, 1, 32'h11112222, 1, 0); do_cycle();
        check("orphan_valid", obs_wb_valid, 1'b0);
        check("orphan_pending", obs_ld_pending, 1'b1);
        drive(0, 1, 32'h33334444, 1, 0); do_cycle();
        check("second_valid", obs_wb_valid, 1'b1);
        check("second_wdata", obs_wdata, 32'h33334444);

        // exception-tagged instruction, then flush racing EX valid
        set_ex(32'h1c000014, 32'h77, 0, 5'd0, 0, 5'b00000, 1, 0);
        drive(1, 0, 0, 1, 0); do_cycle();
        drive(0, 0, 0, 1, 0); do_cycle();
        check("exc_mem_ex", obs_mem_ex, 1'b1);
        check("exc_valid", obs_wb_valid, 1'b1);
        set_ex(32'h1c000018, 32'h88, 1, 5'd2, 0, 5'b00000, 0, 0);
        drive(1, 0, 0, 1, 1); do_cycle();
        check("flush_wb_valid", obs_wb_valid, 1'b0);
        drive(0, 0, 0, 1, 0); do_cycle();
        check("flush_fwd_we", obs_fwd_we, 1'b0);
        check("flush_allowin", obs_allowin, 1'b1);

        run_random(1500);
        do_reset();
        run_random(1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
